pulse_framer: RTL and testbench
===============================

PULSE_FRAMER -- requirements
Module: pulse_framer

Interface
REQ-001 Parameter MAX_PULSE_SIZE, default 8192, largest pulse length in samples.
REQ-002 Parameter WIDTH, default 32, sample width (16-bit I, 16-bit Q).
REQ-003 Parameter USER_WIDTH, default 128, sideband width (CHDR header).
REQ-004 clk  in  1  ce_clk domain clock; the only clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 clear  in  1  synchronous abort; single-cycle strobe.
REQ-007 arm  in  1  single-cycle strobe that starts a framing burst.
REQ-008 pulse_size  in  32  samples per pulse, from setting register.
REQ-009 num_avg  in  32  pulses per burst, from setting register.
REQ-010 i_tdata/i_tuser/i_tvalid/i_tlast/i_tready  WIDTH/USER_WIDTH/1/1/out-1  AXI-S input from axi_wrapper m_axis_data.
REQ-011 o_tdata/o_tuser/o_tvalid/o_tlast/o_tready  WIDTH/USER_WIDTH/1/1/in-1  AXI-S output to pulse_avg_core i_*.
REQ-012 busy  out  1  high while not in IDLE.
REQ-013 done  out  1  one-cycle strobe at burst completion.
REQ-014 pulse_count  out  32  pulses completed in the current burst.

Function
REQ-015 FSM states: IDLE, FRAME, FLUSH.
REQ-016 IDLE: i_tready=1, input samples discarded, o_tvalid=0.
REQ-017 arm in IDLE latches sz=clamp(pulse_size) and na=num_avg, zeroes counters, and enters FRAME next cycle.
REQ-018 clamp: pulse_size 0 -> 1; pulse_size > MAX_PULSE_SIZE -> MAX_PULSE_SIZE; num_avg 0 -> 1.
REQ-019 arm outside IDLE is ignored; later pulse_size/num_avg changes are ignored until the next arm.
REQ-020 FRAME: one output register stage; latency is exactly 1 cycle from input acceptance to o_tvalid.
REQ-021 i_tready = !o_tvalid || o_tready while in FRAME; o_tvalid/o_tdata/o_tlast/o_tuser hold stable until o_tready.
REQ-022 i_tlast is ignored; o_tlast=1 on the sample where sample_cnt == sz-1.
REQ-023 sample_cnt is 14 bits, clog2(MAX_PULSE_SIZE)+1; it increments per accepted input and wraps to 0 after sz-1.
REQ-024 o_tuser equals the i_tuser captured on the first sample of each pulse, held for the entire pulse.
REQ-025 After the sample with o_tlast is accepted at the input, pulse_count increments.
REQ-026 When that sample is pulse na-1, the FSM enters FLUSH and i_tready=0.
REQ-027 FLUSH: on the output handshake of the final o_tlast, done=1 for one cycle, then the FSM returns to IDLE.
REQ-028 pulse_count holds its final value in IDLE until the next arm or clear.
REQ-029 o_tready low stalls the block without sample loss or duplication.
REQ-030 clear in any state returns to IDLE next cycle, drops the output register (o_tvalid=0), zeroes counters, and suppresses done.
REQ-031 clear and arm in the same cycle: clear wins and the FSM stays in IDLE.

Reset
REQ-032 reset has priority over clear and arm and acts identically to clear.
REQ-033 Reset values: state=IDLE, o_tvalid=0, o_tlast=0, o_tdata=0, o_tuser=0, busy=0, done=0, pulse_count=0.
REQ-034 Reset mid-pulse discards the partial pulse; the next arm starts framing at sample 0.

Structure
REQ-035 FSM state encodings and the MAX_PULSE_SIZE default live in pulse_avg_pkg, shared with pulse_avg_core.
REQ-036 SR addresses stay in pulse_avg_regs.vh; this block takes pulse_size/num_avg as ports.
REQ-037 One natural sub-module: axi_fifo_flop, used as the output register stage.
REQ-038 noc_block_pulse_avg instantiates the block between axi_wrapper m_axis_data and pulse_avg_core.

Verification
REQ-039 arm, pulse_size=4, num_avg=2, 10 samples, o_tready=1 -> 8 samples out, o_tlast on samples 3 and 7, done on the cycle of sample 7, pulse_count=2, last 2 samples dropped.
REQ-040 pulse_size=0 and num_avg=0 -> exactly 1 sample out with o_tlast=1, then done.
REQ-041 pulse_size=20000 -> o_tlast after 8192 samples.
REQ-042 pulse_size=4, random o_tready (50%) -> same data order as REQ-039 with no loss or duplication, o_tuser constant per pulse and matching the first input tuser.
REQ-043 clear asserted at sample 2 of pulse 1 -> o_tvalid=0 next cycle, no done, pulse_count=0; a subsequent arm restarts framing at sample 0.
REQ-044 arm repeated during FRAME, plus a pulse_size change mid-burst -> no effect; framing continues with the latched sz.

Source files
------------

// File: rtl/pulse_avg_pkg.sv
// Shared definitions for the pulse averaging datapath (framer and averaging core).
package pulse_avg_pkg;

    // Largest pulse, in samples, that the averaging path supports.
    localparam int unsigned MaxPulseSizeDefault = 8192;

    // Framer control states.
    typedef enum logic [1:0] {
        StIdle,
        StFrame,
        StFlush
    } pulse_state_e;

endpackage

// File: rtl/axi_fifo_flop.sv
// Single-entry AXI-Stream register slice with full throughput and a synchronous drop.
module axi_fifo_flop #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic [Width-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [Width-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    logic [Width-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    // Accept whenever the slot is empty or is being drained this cycle.
    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_data_o  = data_q;
    assign out_valid_o = valid_q;

    // Next-state: load on input handshake, empty on output handshake, clear drops the entry.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (in_valid_i && in_ready_o) begin
            valid_d = 1'b1;
            data_d  = in_data_i;
        end else if (out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Storage register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/pulse_framer.sv
// Cuts an incoming sample stream into num_avg pulses of pulse_size samples after an arm strobe,
// marking the last sample of each pulse and holding the pulse's first tuser for all its samples.
module pulse_framer
    import pulse_avg_pkg::*;
#(
    parameter int unsigned MAX_PULSE_SIZE = MaxPulseSizeDefault,
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned USER_WIDTH     = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  arm,
    input  logic [31:0]           pulse_size,
    input  logic [31:0]           num_avg,
    input  logic [WIDTH-1:0]      i_tdata,
    input  logic [USER_WIDTH-1:0] i_tuser,
    input  logic                  i_tvalid,
    input  logic                  i_tlast,
    output logic                  i_tready,
    output logic [WIDTH-1:0]      o_tdata,
    output logic [USER_WIDTH-1:0] o_tuser,
    output logic                  o_tvalid,
    output logic                  o_tlast,
    input  logic                  o_tready,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           pulse_count
);

    localparam int unsigned CntW  = $clog2(MAX_PULSE_SIZE) + 1;
    localparam int unsigned FlopW = 1 + USER_WIDTH + WIDTH;

    pulse_state_e          state_q, state_d;
    logic [CntW-1:0]       sz_q, sz_d;
    logic [31:0]           na_q, na_d;
    logic [CntW-1:0]       sample_cnt_q, sample_cnt_d;
    logic [31:0]           pulse_count_q, pulse_count_d;
    logic [USER_WIDTH-1:0] user_q, user_d;

    logic                  flop_in_valid, flop_in_ready;
    logic                  first_sample, last_sample;
    logic [USER_WIDTH-1:0] cur_user;
    logic [FlopW-1:0]      flop_out;

    // Incoming tlast is deliberately ignored; framing is purely count based.
    logic unused_tlast;
    assign unused_tlast = i_tlast;

    assign first_sample = (sample_cnt_q == '0);
    assign last_sample  = (sample_cnt_q == sz_q - CntW'(1));
    assign cur_user     = first_sample ? i_tuser : user_q;

    // Next-state, handshake and done logic; clear or reset overrides everything else.
    always_comb begin
        state_d       = state_q;
        sz_d          = sz_q;
        na_d          = na_q;
        sample_cnt_d  = sample_cnt_q;
        pulse_count_d = pulse_count_q;
        user_d        = user_q;
        flop_in_valid = 1'b0;
        i_tready      = 1'b0;
        done          = 1'b0;

        unique case (state_q)
            StIdle: begin
                i_tready = 1'b1;
                if (arm) begin
                    if (pulse_size == 32'd0) begin
                        sz_d = CntW'(1);
                    end else if (pulse_size > 32'(MAX_PULSE_SIZE)) begin
                        sz_d = CntW'(MAX_PULSE_SIZE);
                    end else begin
                        sz_d = CntW'(pulse_size);
                    end
                    na_d          = (num_avg == 32'd0) ? 32'd1 : num_avg;
                    sample_cnt_d  = '0;
                    pulse_count_d = '0;
                    state_d       = StFrame;
                end
            end
            StFrame: begin
                i_tready      = flop_in_ready;
                flop_in_valid = i_tvalid;
                if (i_tvalid && flop_in_ready) begin
                    if (first_sample) begin
                        user_d = i_tuser;
                    end
                    if (last_sample) begin
                        sample_cnt_d  = '0;
                        pulse_count_d = pulse_count_q + 32'd1;
                        if (pulse_count_q == na_q - 32'd1) begin
                            state_d = StFlush;
                        end
                    end else begin
                        sample_cnt_d = sample_cnt_q + CntW'(1);
                    end
                end
            end
            StFlush: begin
                // The register slot holds exactly the final sample of the burst here.
                if (o_tvalid && o_tready && o_tlast) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (clear || reset) begin
            state_d       = StIdle;
            sample_cnt_d  = '0;
            pulse_count_d = '0;
            flop_in_valid = 1'b0;
            done          = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            sz_q          <= CntW'(1);
            na_q          <= 32'd1;
            sample_cnt_q  <= '0;
            pulse_count_q <= '0;
            user_q        <= '0;
        end else begin
            state_q       <= state_d;
            sz_q          <= sz_d;
            na_q          <= na_d;
            sample_cnt_q  <= sample_cnt_d;
            pulse_count_q <= pulse_count_d;
            user_q        <= user_d;
        end
    end

    axi_fifo_flop #(
        .Width (FlopW)
    ) u_out_reg (
        .clk_i       (clk),
        .rst_i       (reset),
        .clear_i     (clear),
        .in_data_i   ({last_sample, cur_user, i_tdata}),
        .in_valid_i  (flop_in_valid),
        .in_ready_o  (flop_in_ready),
        .out_data_o  (flop_out),
        .out_valid_o (o_tvalid),
        .out_ready_i (o_tready)
    );

    assign o_tlast     = flop_out[FlopW-1];
    assign o_tuser     = flop_out[WIDTH +: USER_WIDTH];
    assign o_tdata     = flop_out[WIDTH-1:0];
    assign busy        = (state_q != StIdle);
    assign pulse_count = pulse_count_q;

endmodule

// File: tb/tb_pulse_framer.sv
// Scoreboard bench for pulse_framer: the driver predicts each framed sample from its own
// sz/na model and the monitor pops and compares as samples leave the output port.
module tb_pulse_framer;

    localparam int W     = 32;
    localparam int UW    = 128;
    localparam int MaxSz = 8192;

    typedef struct {
        logic [W-1:0]  data;
        logic [UW-1:0] user;
        logic          last;
        logic          fin;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          arm = 1'b0;
    logic [31:0]   pulse_size = '0;
    logic [31:0]   num_avg = '0;
    logic [W-1:0]  i_tdata = '0;
    logic [UW-1:0] i_tuser = '0;
    logic          i_tvalid = 1'b0;
    logic          i_tlast = 1'b0;
    logic          i_tready;
    logic [W-1:0]  o_tdata;
    logic [UW-1:0] o_tuser;
    logic          o_tvalid;
    logic          o_tlast;
    logic          o_tready = 1'b1;
    logic          busy;
    logic          done;
    logic [31:0]   pulse_count;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            done_seen = 0;
    bit            rand_ready = 1'b0;
    int unsigned   m_sz = 1, m_na = 1, bidx = 0;
    logic [UW-1:0] m_user = '0;

    pulse_framer dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .arm         (arm),
        .pulse_size  (pulse_size),
        .num_avg     (num_avg),
        .i_tdata     (i_tdata),
        .i_tuser     (i_tuser),
        .i_tvalid    (i_tvalid),
        .i_tlast     (i_tlast),
        .i_tready    (i_tready),
        .o_tdata     (o_tdata),
        .o_tuser     (o_tuser),
        .o_tvalid    (o_tvalid),
        .o_tlast     (o_tlast),
        .o_tready    (o_tready),
        .busy        (busy),
        .done        (done),
        .pulse_count (pulse_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output back-pressure: always ready, or a coin flip per cycle.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            o_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pop the scoreboard on each output handshake and watch stall stability and done.
    initial begin
        exp_t                e;
        bit                  prev_hold;
        logic [UW+W:0]       hold_word;
        prev_hold = 1'b0;
        hold_word = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    n_checks++;
                    if (o_tvalid !== 1'b1 || {o_tlast, o_tuser, o_tdata} !== hold_word) begin
                        n_fail++;
                        $display("FAIL stall_hold: got valid=%b word=%h, required valid=1 word=%h",
                                 o_tvalid, {o_tlast, o_tuser, o_tdata}, hold_word);
                    end
                end
                if (o_tvalid === 1'b1 && o_tready === 1'b1) begin
                    n_checks++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_output: got data=%h last=%b, required none",
                                 o_tdata, o_tlast);
                    end else begin
                        e = sb.pop_front();
                        if (o_tdata !== e.data || o_tuser !== e.user || o_tlast !== e.last) begin
                            n_fail++;
                            $display("FAIL sample: got data=%h last=%b user=%h, required data=%h last=%b user=%h",
                                     o_tdata, o_tlast, o_tuser, e.data, e.last, e.user);
                        end
                        n_checks++;
                        if (done !== e.fin) begin
                            n_fail++;
                            $display("FAIL done_strobe: got %b, required %b", done, e.fin);
                        end
                        if (!rand_ready) begin
                            n_checks++;
                            if (cyc != e.cyc + 1) begin
                                n_fail++;
                                $display("FAIL latency: got %0d cycles, required 1", cyc - e.cyc);
                            end
                        end
                    end
                end else begin
                    n_checks++;
                    if (done !== 1'b0) begin
                        n_fail++;
                        $display("FAIL spurious_done: got %b, required 0", done);
                    end
                end
                if (done === 1'b1) done_seen++;
                prev_hold = (o_tvalid === 1'b1) && (o_tready === 1'b0) && !clear;
                hold_word = {o_tlast, o_tuser, o_tdata};
            end
        end
    end

    task automatic do_arm(input logic [31:0] ps, input logic [31:0] na);
        arm        = 1'b1;
        pulse_size = ps;
        num_avg    = na;
        m_sz       = (ps == 0) ? 1 : ((ps > MaxSz) ? MaxSz : ps);
        m_na       = (na == 0) ? 1 : na;
        bidx       = 0;
        @(posedge clk);
        #1;
        arm = 1'b0;
    endtask

    task automatic send(input int n);
        for (int k = 0; k < n; k++) begin
            logic [UW-1:0] u;
            bit            ok;
            int            waited;
            exp_t          e;
            u        = {$urandom, $urandom, $urandom, $urandom};
            i_tvalid = 1'b1;
            i_tdata  = $urandom;
            i_tuser  = u;
            i_tlast  = 1'($urandom_range(0, 1));
            ok       = 1'b0;
            waited   = 0;
            while (!ok) begin
                @(negedge clk);
                if (i_tready === 1'b1) ok = 1'b1;
                else if (++waited > 2000) break;
            end
            if (!ok) begin
                n_checks++;
                n_fail++;
                $display("FAIL input_accept: got no i_tready in 2000 cycles, required acceptance");
                i_tvalid = 1'b0;
                return;
            end
            if (bidx < m_sz * m_na) begin
                if (bidx % m_sz == 0) m_user = u;
                e.data = i_tdata;
                e.user = m_user;
                e.last = (bidx % m_sz == m_sz - 1);
                e.fin  = (bidx == m_sz * m_na - 1);
                e.cyc  = cyc;
                sb.push_back(e);
            end
            bidx++;
            @(posedge clk);
            #1;
        end
        i_tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while ((busy !== 1'b0 || sb.size() != 0) && waited < 40000);
        n_checks++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL burst_end: got busy=%b pending=%0d, required busy=0 pending=0",
                     busy, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_burst(input string name, input int d0, input logic [31:0] pc);
        n_checks++;
        if (done_seen != d0 + 1) begin
            n_fail++;
            $display("FAIL %s_done_count: got %0d, required %0d", name, done_seen - d0, 1);
        end
        n_checks++;
        if (pulse_count !== pc) begin
            n_fail++;
            $display("FAIL %s_pulse_count: got %0d, required %0d", name, pulse_count, pc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({o_tvalid, o_tlast, busy, done, i_tready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_ctrl: got valid,last,busy,done,ready=%b, required 00001",
                     {o_tvalid, o_tlast, busy, done, i_tready});
        end
        n_checks++;
        if (o_tdata !== '0 || o_tuser !== '0 || pulse_count !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got data=%h user=%h count=%0d, required all 0",
                     o_tdata, o_tuser, pulse_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int d0 = done_seen;
        do_arm(32'd4, 32'd2);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got %b, required 1", busy);
        end
        send(10);
        wait_idle();
        check_burst("basic", d0, 32'd2);
    endtask

    task automatic test_clamp_zero();
        int d0 = done_seen;
        do_arm(32'd0, 32'd0);
        send(1);
        wait_idle();
        check_burst("clamp_zero", d0, 32'd1);
    endtask

    task automatic test_clamp_max();
        int d0 = done_seen;
        do_arm(32'd20000, 32'd1);
        send(MaxSz);
        wait_idle();
        check_burst("clamp_max", d0, 32'd1);
    endtask

    task automatic test_stall();
        int d0 = done_seen;
        rand_ready = 1'b1;
        do_arm(32'd4, 32'd2);
        send(8);
        wait_idle();
        rand_ready = 1'b0;
        check_burst("stall", d0, 32'd2);
    endtask

    task automatic test_clear();
        int d0 = done_seen;
        do_arm(32'd4, 32'd2);
        send(6);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_tvalid !== 1'b0 || busy !== 1'b0 || pulse_count !== '0) begin
            n_fail++;
            $display("FAIL clear_state: got valid=%b busy=%b count=%0d, required 0 0 0",
                     o_tvalid, busy, pulse_count);
        end
        n_checks++;
        if (done_seen != d0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL clear_flush: got dones=%0d pending=%0d, required 0 0",
                     done_seen - d0, sb.size());
        end
        @(posedge clk);
        #1;
        do_arm(32'd4, 32'd1);
        send(4);
        wait_idle();
        check_burst("clear_rearm", d0, 32'd1);
    endtask

    task automatic test_reset_mid();
        int d0;
        do_arm(32'd4, 32'd1);
        send(2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        n_checks++;
        if (o_tvalid !== 1'b0 || busy !== 1'b0 || pulse_count !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got valid=%b busy=%b count=%0d, required 0 0 0",
                     o_tvalid, busy, pulse_count);
        end
        @(posedge clk);
        #1;
        d0 = done_seen;
        do_arm(32'd4, 32'd1);
        send(4);
        wait_idle();
        check_burst("reset_rearm", d0, 32'd1);
    endtask

    task automatic test_rearm_ignored();
        int d0 = done_seen;
        do_arm(32'd4, 32'd2);
        send(2);
        // Second arm and new settings mid-burst must not disturb the latched framing.
        arm        = 1'b1;
        pulse_size = 32'd3;
        num_avg    = 32'd5;
        @(posedge clk);
        #1;
        arm = 1'b0;
        send(6);
        wait_idle();
        check_burst("rearm", d0, 32'd2);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp_zero();
        test_clamp_max();
        test_stall();
        test_clear();
        test_reset_mid();
        test_rearm_ignored();
        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
